vga_scan_gen: RTL

- VGA raster timing generator and pixel fetch stage.
- Scans the frame and issues pixel coordinates to the frame source. Captures the returned 12-bit RGB444 pixel (R[11:8], G[7:4], B[3:0]).
- Drives the colour expander that follows it with aligned pixel data, hsync, vsync and display enable.
- Sits between the frame source and the 12-to-24-bit colour expander.

---
 rtl/vga_scan_gen_if.sv | 24 ++
 rtl/vga_scan_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen_if.sv
// rtl/vga_scan_gen_if.sv - pixel fetch and video output bundle of the VGA scan generator
interface vga_scan_gen_if #(
   parameter int CW = 11
) ();
   logic          pix_req;
   logic [CW-1:0] pix_x;
   logic [CW-1:0] pix_y;
   logic [11:0]   pix_in;
   logic [11:0]   d_out;
   logic          hsync;
   logic          vsync;
   logic          de;
   logic          frame_start;

   modport master (
      output pix_req, pix_x, pix_y, d_out, hsync, vsync, de, frame_start,
      input  pix_in
   );

   modport slave (
      input  pix_req, pix_x, pix_y, d_out, hsync, vsync, de, frame_start,
      output pix_in
   );
endinterface

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - VGA raster timing generator and pixel fetch stage
// Optional colour-bar test pattern behind macro VGA_TESTPAT_EN (adds test_sel input).
module vga_scan_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0,
   parameter int   CW       = 11
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce,
`ifdef VGA_TESTPAT_EN
   input  logic test_sel,
`endif
   vga_scan_gen_if.master vid
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CW-1:0] ZERO     = '0;

   // raster counters
   logic [CW-1:0] h_q, h_d;
   logic [CW-1:0] v_q, v_d;

   // stage 0: issued coordinate plus decoded region flags (sync flags are active-high here)
   logic [CW-1:0] x0_q, y0_q;
   logic          req0_q, hs0_q, vs0_q, org0_q;

   // stage 1: returned pixel is valid while these are held
   logic          de1_q, hs1_q, vs1_q, fs1_q;

   // stage 2: outputs
   logic [11:0]   dout_q, dout_d;
   logic          de_q, hsync_q, vsync_q;
   logic          fs_q, fs_d;
   logic [11:0]   pix_sel;

   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (h_q == H_LAST) begin
         h_d = ZERO;
         v_d = (v_q == V_LAST) ? ZERO : v_q + 1'b1;
      end
   end

`ifdef VGA_TESTPAT_EN
   logic [CW-1:0] x1_q;
   logic          ts1_q;
   logic [2:0]    bar_idx;
   logic [11:0]   bar_rgb;

   // bar = x*8/H_ACTIVE, found as the number of bar edges at or below x
   always_comb begin
      bar_idx = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (x1_q >= CW'((k * H_ACTIVE + 7) / 8))
            bar_idx = 3'(k);
      end
   end

   always_comb begin
      case (bar_idx)
         3'd0:    bar_rgb = 12'hFFF;
         3'd1:    bar_rgb = 12'hFF0;
         3'd2:    bar_rgb = 12'h0FF;
         3'd3:    bar_rgb = 12'h0F0;
         3'd4:    bar_rgb = 12'hF0F;
         3'd5:    bar_rgb = 12'hF00;
         3'd6:    bar_rgb = 12'h00F;
         default: bar_rgb = 12'h000;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x1_q  <= '0;
         ts1_q <= 1'b0;
      end else if (ce) begin
         x1_q  <= x0_q;
         ts1_q <= test_sel;
      end
   end

   assign pix_sel = ts1_q ? bar_rgb : vid.pix_in;
`else
   assign pix_sel = vid.pix_in;
`endif

   always_comb begin
      dout_d = de1_q ? pix_sel : 12'h000;
      fs_d   = ce & fs1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q     <= '0;
         v_q     <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         req0_q  <= 1'b0;
         hs0_q   <= 1'b0;
         vs0_q   <= 1'b0;
         org0_q  <= 1'b0;
         de1_q   <= 1'b0;
         hs1_q   <= 1'b0;
         vs1_q   <= 1'b0;
         fs1_q   <= 1'b0;
         dout_q  <= 12'h000;
         de_q    <= 1'b0;
         hsync_q <= ~SYNC_POL;
         vsync_q <= ~SYNC_POL;
         fs_q    <= 1'b0;
      end else begin
         // frame_start is a single-clk strobe, so it clears even when ce is low
         fs_q <= fs_d;
         if (ce) begin
            h_q     <= h_d;
            v_q     <= v_d;
            x0_q    <= h_q;
            y0_q    <= v_q;
            req0_q  <= (h_q < H_ACT) && (v_q < V_ACT);
            hs0_q   <= (h_q >= HS_BEG) && (h_q < HS_END);
            vs0_q   <= (v_q >= VS_BEG) && (v_q < VS_END);
            org0_q  <= (h_q == ZERO) && (v_q == ZERO);
            de1_q   <= req0_q;
            hs1_q   <= hs0_q;
            vs1_q   <= vs0_q;
            fs1_q   <= org0_q & req0_q;
            dout_q  <= dout_d;
            de_q    <= de1_q;
            hsync_q <= hs1_q ? SYNC_POL : ~SYNC_POL;
            vsync_q <= vs1_q ? SYNC_POL : ~SYNC_POL;
         end
      end
   end

   assign vid.pix_x       = x0_q;
   assign vid.pix_y       = y0_q;
   assign vid.pix_req     = req0_q;
   assign vid.d_out       = dout_q;
   assign vid.de          = de_q;
   assign vid.hsync       = hsync_q;
   assign vid.vsync       = vsync_q;
   assign vid.frame_start = fs_q;
endmodule
